// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 fetch stage.
package lc3_fetch_pkg;

    localparam int unsigned      ADDR_W           = 16;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h3000;

    typedef enum logic {FS_RUN, FS_BUBBLE} fetch_state_t;

endpackage

// File: rtl/lc3_fetch_sat_cnt.sv
// 16-bit saturating event counter with asynchronous active-low reset.
module lc3_fetch_sat_cnt
    import lc3_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    // Count increment requests, holding at all-ones once reached.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch stage: program counter, instruction-memory read strobe and
// post-redirect bubble insertion.
// Optional feature macro: FETCH_REDIRECT_CNT_EN adds the redirect_cnt port
// and a saturating count of accepted redirects.
module lc3_fetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC         = DEFAULT_RESET_PC,
    parameter int unsigned       REDIRECT_BUBBLES = 1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] taddr,
    input  logic              enable_fetch,
    input  logic              enable_updatePC,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              instrmem_rd,
`ifdef FETCH_REDIRECT_CNT_EN
    output logic [ADDR_W-1:0] redirect_cnt,
`endif
    output logic              fetch_valid
);

    // Reload value only meaningful when bubbles are configured.
    localparam bit         HAS_BUBBLE = (REDIRECT_BUBBLES != 0);
    localparam logic [1:0] BUB_RELOAD = HAS_BUBBLE ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;

    fetch_state_t state;
    logic [1:0]   bub_cnt;
    logic         redirect;

    assign redirect = enable_updatePC && br_taken;

    // Next-PC and read strobe are purely combinational.
    always_comb begin
        npc         = pc + 16'd1;
        instrmem_rd = (state == FS_RUN) && enable_fetch;
    end

    // PC, bubble FSM and read-valid pipeline register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            state       <= FS_RUN;
            bub_cnt     <= '0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= instrmem_rd;
            case (state)
                FS_RUN: begin
                    if (enable_updatePC) begin
                        if (br_taken) begin
                            pc <= taddr;
                            if (HAS_BUBBLE) begin
                                state   <= FS_BUBBLE;
                                bub_cnt <= BUB_RELOAD;
                            end
                        end else begin
                            pc <= pc + 16'd1;
                        end
                    end
                end
                FS_BUBBLE: begin
                    // A taken redirect restarts the bubble; sequential updates are dropped.
                    if (redirect) begin
                        pc      <= taddr;
                        bub_cnt <= BUB_RELOAD;
                    end else if (bub_cnt == 2'd0) begin
                        state <= FS_RUN;
                    end else begin
                        bub_cnt <= bub_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= FS_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    lc3_fetch_sat_cnt u_redirect_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (redirect),
        .count (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: one instance with two bubble cycles,
// one with none. Driver pushes per-cycle expectations; monitor checks them.
module tb_lc3_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = '0;
    logic        enable_fetch = 1'b0;
    logic        enable_updatePC = 1'b0;

    logic [15:0] pc_a, npc_a, pc_b, npc_b;
    logic        rd_a, fv_a, rd_b, fv_b;
    logic [15:0] cnt_a, cnt_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    lc3_fetch_unit #(.RESET_PC(16'h3000), .REDIRECT_BUBBLES(2)) dut_a (
        .clock           (clock),
        .reset           (reset),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .pc              (pc_a),
        .npc             (npc_a),
        .instrmem_rd     (rd_a),
`ifdef FETCH_REDIRECT_CNT_EN
        .redirect_cnt    (cnt_a),
`endif
        .fetch_valid     (fv_a)
    );

    lc3_fetch_unit #(.RESET_PC(16'h3000), .REDIRECT_BUBBLES(0)) dut_b (
        .clock           (clock),
        .reset           (reset),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .pc              (pc_b),
        .npc             (npc_b),
        .instrmem_rd     (rd_b),
`ifdef FETCH_REDIRECT_CNT_EN
        .redirect_cnt    (cnt_b),
`endif
        .fetch_valid     (fv_b)
    );

`ifndef FETCH_REDIRECT_CNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

    typedef struct {
        int          row;
        logic        sel;
        logic [15:0] pc;
        logic        rd;
        logic        fv;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(input int row, input string name,
                                input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, req);
        end
    endfunction

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] pc_s, npc_s, cnt_s;
            logic        rd_s, fv_s;
            e = sb.pop_front();
            pc_s  = e.sel ? pc_b  : pc_a;
            npc_s = e.sel ? npc_b : npc_a;
            rd_s  = e.sel ? rd_b  : rd_a;
            fv_s  = e.sel ? fv_b  : fv_a;
            cnt_s = e.sel ? cnt_b : cnt_a;
            chk(e.row, "pc", pc_s, e.pc);
            chk(e.row, "npc", npc_s, e.pc + 16'd1);
            chk(e.row, "instrmem_rd", {15'd0, rd_s}, {15'd0, e.rd});
            chk(e.row, "fetch_valid", {15'd0, fv_s}, {15'd0, e.fv});
`ifdef FETCH_REDIRECT_CNT_EN
            chk(e.row, "redirect_cnt", cnt_s, e.cnt);
`endif
        end
    end

    int row_no = 0;

    // Drive one cycle of inputs and record the outputs expected in that cycle.
    task automatic row(input logic rst, input logic ef, input logic eu,
                       input logic bt, input logic [15:0] ta, input logic sel,
                       input logic [15:0] epc, input logic erd, input logic efv,
                       input logic [15:0] ecnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rst;
        enable_fetch    = ef;
        enable_updatePC = eu;
        br_taken        = bt;
        taddr           = ta;
        e.row = row_no;
        e.sel = sel;
        e.pc  = epc;
        e.rd  = erd;
        e.fv  = efv;
        e.cnt = ecnt;
        sb.push_back(e);
        row_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst ef eu bt taddr     sel pc       rd fv cnt
        // Bench A (two bubbles): reset, sequential fetch
        row(0, 1, 1, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 1, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 1, 0, 16'h0000, 0, 16'h3001, 1, 1, 16'd0);
        row(1, 1, 1, 0, 16'h0000, 0, 16'h3002, 1, 1, 16'd0);
        // redirect to 4123, then re-redirect to 5000 inside the bubble
        row(1, 1, 1, 1, 16'h4123, 0, 16'h3003, 1, 1, 16'd0);
        row(1, 1, 1, 1, 16'h5000, 0, 16'h4123, 0, 1, 16'd1);
        row(1, 1, 1, 0, 16'h0000, 0, 16'h5000, 0, 0, 16'd2);
        row(1, 1, 0, 0, 16'h0000, 0, 16'h5000, 0, 0, 16'd2);
        row(1, 1, 0, 0, 16'h0000, 0, 16'h5000, 1, 0, 16'd2);
        row(1, 0, 0, 0, 16'h0000, 0, 16'h5000, 0, 1, 16'd2);
        // redirect to FFFF then sequential wrap to 0000
        row(1, 1, 1, 1, 16'hFFFF, 0, 16'h5000, 1, 0, 16'd2);
        row(1, 1, 0, 0, 16'h0000, 0, 16'hFFFF, 0, 1, 16'd3);
        row(1, 1, 0, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 16'd3);
        row(1, 1, 1, 0, 16'h0000, 0, 16'hFFFF, 1, 0, 16'd3);
        row(1, 1, 1, 1, 16'h1234, 0, 16'h0000, 1, 1, 16'd3);
        // reset asserted mid-bubble takes effect immediately
        row(1, 1, 0, 0, 16'h0000, 0, 16'h1234, 0, 1, 16'd4);
        row(0, 1, 1, 1, 16'h7777, 0, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 0, 0, 16'h0000, 0, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 0, 0, 16'h0000, 0, 16'h3000, 1, 1, 16'd0);
        // Bench B (no bubbles): back-to-back redirects without read gaps
        row(0, 1, 0, 0, 16'h0000, 1, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 1, 1, 16'h1000, 1, 16'h3000, 1, 0, 16'd0);
        row(1, 1, 1, 1, 16'h2000, 1, 16'h1000, 1, 1, 16'd1);
        row(1, 1, 1, 0, 16'h0000, 1, 16'h2000, 1, 1, 16'd2);
        row(1, 1, 0, 0, 16'h0000, 1, 16'h2001, 1, 1, 16'd2);

        @(posedge clock);
        @(negedge clock);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_unit.md
# lc3_fetch_unit

Fetch stage of the LC-3 pipeline: the responder end of the fetch_in bus. It consumes br_taken, taddr, enable_fetch and enable_updatePC. It maintains the program counter, issues instruction-memory reads, and inserts a configurable number of bubble cycles after every taken redirect. The fetch_in agent drives its inputs; the instruction memory and decode stage consume its outputs.

## Interface
- RESET_PC, 16'h3000: PC value loaded on reset.
- REDIRECT_BUBBLES, 1: read-suppressed cycles after an accepted redirect; legal range 0–3.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- br_taken  input  1  qualifies taddr as the next PC when enable_updatePC is high.
- taddr  input  16  branch/jump target address.
- enable_fetch  input  1  permits an instruction-memory read this cycle.
- enable_updatePC  input  1  permits a PC update at this rising edge.
- pc  output  16  current fetch address.
- npc  output  16  pc + 1, modulo 2^16.
- instrmem_rd  output  1  instruction-memory read strobe.
- fetch_valid  output  1  instruction data for the previous cycle's read is valid.
- redirect_cnt  output  16  number of accepted redirects; present only with FETCH_REDIRECT_CNT_EN.

## Operation
- States: FS_RUN, FS_BUBBLE. There is a 2-bit bubble down-counter, bub_cnt.
- FS_RUN behaviour:
  - instrmem_rd = enable_fetch (combinational).
  - At a rising edge with enable_updatePC = 1 and br_taken = 0: pc <= pc + 1.
  - At a rising edge with enable_updatePC = 1 and br_taken = 1: pc <= taddr. This is an accepted redirect. If REDIRECT_BUBBLES > 0: go to FS_BUBBLE and set bub_cnt = REDIRECT_BUBBLES − 1.
  - enable_updatePC = 0: pc holds and br_taken is ignored.
- FS_BUBBLE behaviour:
  - instrmem_rd = 0 regardless of enable_fetch.
  - Each edge: if bub_cnt == 0, go to FS_RUN; otherwise decrement bub_cnt.
  - Non-taken enable_updatePC is ignored and pc holds.
  - Taken enable_updatePC is accepted: pc <= taddr and bub_cnt reloads to REDIRECT_BUBBLES − 1. This restarts the bubble.
- REDIRECT_BUBBLES = 0: FS_BUBBLE is unreachable, and a redirect is followed immediately by a read at taddr.
- npc is combinational from pc; 16'hFFFF + 1 wraps to 16'h0000. pc increments wrap the same way.
- fetch_valid is registered: fetch_valid <= instrmem_rd.
- enable_fetch and enable_updatePC are independent. A read and a PC update in the same cycle read the old pc, and the update takes effect at the edge.

## Timing
- Reset (asynchronous assert, synchronous release at the first edge after deassertion):
  - pc = RESET_PC, state = FS_RUN, bub_cnt = 0.
  - fetch_valid = 0, redirect_cnt = 0.
  - instrmem_rd follows enable_fetch; npc = RESET_PC + 1.
- Reset mid-bubble or mid-redirect aborts the operation immediately; no pending redirect survives.
- Latency:
  - pc updates 1 cycle after the enable_updatePC sample.
  - First post-redirect instrmem_rd comes REDIRECT_BUBBLES cycles after pc = taddr.
  - fetch_valid lags instrmem_rd by 1 cycle.
- The inputs are sampled only at the rising edge, except enable_fetch, which is combinational to instrmem_rd.

## Configuration
- FETCH_REDIRECT_CNT_EN defined:
  - redirect_cnt port and a 16-bit counter exist.
  - The counter increments on each accepted redirect, in both states, and saturates at 16'hFFFF.
  - It resets to 0.
- FETCH_REDIRECT_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package lc3_fetch_pkg contains:
  - ADDR_W = 16.
  - DEFAULT_RESET_PC = 16'h3000.
  - typedef enum logic {FS_RUN, FS_BUBBLE} fetch_state_t.
- Sub-module lc3_fetch_sat_cnt is the 16-bit saturating counter with increment and reset. It is instantiated only under FETCH_REDIRECT_CNT_EN.

## Test plan
- Reset release, enable_updatePC = 1, br_taken = 0 for 3 cycles -> pc = 3000, 3001, 3002, 3003; npc always pc + 1.
- Redirect with taddr = 16'h4123, REDIRECT_BUBBLES = 2, enable_fetch held 1 -> pc = 4123 next cycle; instrmem_rd = 0 for 2 cycles, then 1; fetch_valid = 0 for the 2 cycles after those.
- Second redirect to 16'h5000 during the bubble -> pc = 5000, bubble restarts with a full 2 cycles; with FETCH_REDIRECT_CNT_EN, redirect_cnt = 2.
- pc = 16'hFFFF with non-taken update -> pc = 16'h0000; npc shows 16'h0000 then 16'h0001.
- reset asserted during FS_BUBBLE -> pc = 3000 immediately, instrmem_rd follows enable_fetch, fetch_valid = 0, redirect_cnt = 0.
- REDIRECT_BUBBLES = 0 with back-to-back redirects to 16'h1000 and 16'h2000 -> no instrmem_rd gaps; pc = 1000 then 2000.
